// File: rtl/relu_vec_if.sv
// Handshake and data bundle for relu_vec: masked operand vectors in, re-masked
// result vector out.
interface relu_vec_if #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
) ();
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [2*N*M-1:0] g_input;
  logic [N*M-1:0]   e_input;
  logic             out_valid;
  logic             out_ready;
  logic [N*M-1:0]   o;
  logic             busy;

  modport master (
    output mode, in_valid, g_input, e_input, out_ready,
    input  in_ready, out_valid, o, busy
  );

  modport slave (
    input  mode, in_valid, g_input, e_input, out_ready,
    output in_ready, out_valid, o, busy
  );
endinterface

// File: rtl/relu_vec.sv
// Masked vector activation: reconstructs x = r1 + (x - r1), applies the selected
// activation, re-masks with r2. One element per cycle through a 2-stage pipeline.
module relu_vec #(
  parameter int unsigned N    = 8,
  parameter int unsigned M    = 4,
  parameter int unsigned FRAC = 0
) (
  input logic      clk,
  input logic      rst,
  relu_vec_if.slave bus
);

  localparam int unsigned IW = $clog2(M + 1);
  localparam logic [IW-1:0] MaxIdx  = IW'(M);
  localparam logic [IW-1:0] LastIdx = IW'(M - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [2*N*M-1:0] g_q, g_d;
  logic [N*M-1:0]   e_q, e_d;
  logic [1:0]       mode_q, mode_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    xidx_q, xidx_d;
  logic [N-1:0]     x_q, x_d;
  logic             xvld_q, xvld_d;
  logic [N*M-1:0]   o_q, o_d;
  logic             ov_q, ov_d;

  int unsigned      s1_i, s2_i;
  logic [N-1:0]     r1_s, e_s, r2_s, relu_s, y_s;

  // Operand select for stage 1 (clipped once the index runs past the vector)
  // and stage 2 (index of the element held in x_q).
  always_comb begin
    s1_i   = (idx_q != MaxIdx) ? 32'(idx_q) : 32'd0;
    s2_i   = 32'(xidx_q);
    r1_s   = g_q[2*N*s1_i + N +: N];
    e_s    = e_q[N*s1_i +: N];
    r2_s   = g_q[2*N*s2_i +: N];
    relu_s = x_q[N-1] ? '0 : x_q;
    y_s    = '0;
    unique case (mode_q)
      2'd0: y_s = relu_s;
      2'd1: y_s = x_q;
      2'd2: y_s[0] = ~x_q[N-1];
      2'd3: y_s = relu_s >> FRAC;
      default: y_s = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    e_d     = e_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    xidx_d  = xidx_q;
    x_d     = x_q;
    xvld_d  = xvld_q;
    o_d     = o_q;
    ov_d    = ov_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          g_d     = bus.g_input;
          e_d     = bus.e_input;
          mode_d  = bus.mode;
          idx_d   = '0;
          xvld_d  = 1'b0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (idx_q != MaxIdx) begin
          x_d    = r1_s + e_s;
          xidx_d = idx_q;
          xvld_d = 1'b1;
          idx_d  = idx_q + IW'(1);
        end else begin
          xvld_d = 1'b0;
        end
        if (xvld_q) begin
          o_d[N*s2_i +: N] = y_s - r2_s;
          if (xidx_q == LastIdx) begin
            state_d = StDone;
            ov_d    = 1'b1;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
          ov_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      g_q     <= '0;
      e_q     <= '0;
      mode_q  <= '0;
      idx_q   <= '0;
      xidx_q  <= '0;
      x_q     <= '0;
      xvld_q  <= 1'b0;
      o_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      e_q     <= e_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      xidx_q  <= xidx_d;
      x_q     <= x_d;
      xvld_q  <= xvld_d;
      o_q     <= o_d;
      ov_q    <= ov_d;
    end
  end

  // in_ready drops combinationally with rst so nothing is offered during reset.
  assign bus.in_ready  = (state_q == StIdle) & ~rst;
  assign bus.busy      = (state_q == StBusy);
  assign bus.out_valid = ov_q;
  assign bus.o         = o_q;

endmodule

// File: tb/tb_relu_vec.sv
// Directed bench for relu_vec: stimulus pushes expected result vectors into a
// scoreboard queue; a negedge monitor pops and compares on each output handshake.
module tb_relu_vec;
  localparam int unsigned N    = 8;
  localparam int unsigned M    = 4;
  localparam int unsigned FRAC = 2;

  logic clk = 1'b0;
  logic rst;

  relu_vec_if #(.N(N), .M(M)) bus ();

  relu_vec #(.N(N), .M(M), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  logic [N*M-1:0] exp_q[$];
  logic [N*M-1:0] mon_exp;

  // Element order in these words: element 3 in the top byte, element 0 in the bottom.
  logic [31:0] r1_v = 32'h7FF08010;
  logic [31:0] e_v  = 32'h00200005;
  logic [31:0] r2_v = 32'h7F000103;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Monitor: every accepted output must match the oldest expected vector.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: got o=%0h, required no output", bus.o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_o", {32'd0, bus.o}, {32'd0, mon_exp});
      end
    end
  end

  // Called at posedge+1 while IDLE; returns at accept edge + 1.
  task automatic drive_vec(input logic [1:0] md, input logic [31:0] r1, input logic [31:0] e,
                           input logic [31:0] r2, input bit push, input logic [31:0] exp_o);
    logic [2*N*M-1:0] g;
    g = '0;
    for (int i = 0; i < int'(M); i++) begin
      g[16*i+8 +: 8] = r1[8*i +: 8];
      g[16*i +: 8]   = r2[8*i +: 8];
    end
    if (push) exp_q.push_back(exp_o);
    bus.mode     = md;
    bus.g_input  = g;
    bus.e_input  = e;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_simple(input string name, input logic [1:0] md, input logic [31:0] exp_o);
    int lat;
    drive_vec(md, r1_v, e_v, r2_v, 1'b1, exp_o);
    check({name, "_busy"}, {63'd0, bus.busy}, 64'd1);
    wait_out(0, lat);
    check({name, "_latency"}, lat, 64'd5);
    @(posedge clk);
    #1;
    check({name, "_ov_one_cycle"}, {63'd0, bus.out_valid}, 64'd0);
    check({name, "_ready_back"}, {63'd0, bus.in_ready}, 64'd1);
  endtask

  int lat;
  int ov_seen;
  logic [N*M-1:0] snap;

  initial begin
    rst           = 1'b1;
    bus.mode      = '0;
    bus.in_valid  = 1'b0;
    bus.g_input   = '0;
    bus.e_input   = '0;
    bus.out_ready = 1'b1;
    #2;
    check("rst_o", {32'd0, bus.o}, 64'd0);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ready_after_rst", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;

    run_simple("relu", 2'd0, 32'h0010FF12);
    run_simple("drelu", 2'd2, 32'h8201FFFE);
    run_simple("relu_shift", 2'd3, 32'hA004FF02);

    // Mode change after accept must not affect the vector in flight.
    drive_vec(2'd1, r1_v, e_v, r2_v, 1'b1, 32'h00107F12);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.mode = 2'd0;
    wait_out(2, lat);
    check("mode_switch_latency", lat, 64'd5);
    @(posedge clk);
    #1;

    // Back-pressure: result held, new request ignored while DONE.
    bus.out_ready = 1'b0;
    drive_vec(2'd0, r1_v, e_v, r2_v, 1'b1, 32'h0010FF12);
    wait_out(0, lat);
    check("bp_latency", lat, 64'd5);
    snap = bus.o;
    check("bp_first_o", {32'd0, snap}, 64'h0010FF12);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        bus.mode     = 2'd1;
        bus.e_input  = '1;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("bp_ov_held", {63'd0, bus.out_valid}, 64'd1);
      check("bp_o_held", {32'd0, bus.o}, {32'd0, snap});
      check("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ov", {63'd0, bus.out_valid}, 64'd0);
    check("bp_release_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    check("bp_no_capture", {63'd0, bus.busy}, 64'd0);

    // Abort mid-BUSY.
    drive_vec(2'd0, r1_v, e_v, r2_v, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_o", {32'd0, bus.o}, 64'd0);
    check("abort_ov", {63'd0, bus.out_valid}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_ready_in_rst", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_ready_after", {63'd0, bus.in_ready}, 64'd1);
    ov_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) ov_seen++;
    end
    check("abort_no_out", ov_seen, 64'd0);
    run_simple("after_abort", 2'd0, 32'h0010FF12);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    check("sb_drained", exp_q.size(), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/relu_vec.md
Name: relu_vec

Overview:
- Sequential, multi-element successor to the single-value masked ReLU in the garbled-circuit layer library.
- Accepts a vector of M masked N-bit values in one handshake:
  - garbler share: r1 (input mask) and r2 (output mask) per element;
  - evaluator share: x - r1 per element.
- Reconstructs each x, applies a selectable activation, re-masks with r2, and returns the whole vector in one handshake.
- Processes one element per cycle through a 2-stage pipeline. This keeps circuit size per clock at one adder pair, as sequential garbling needs.

Parameters:
- N, 8, bit-width of each element (two's complement).
- M, 4, number of elements per vector (M >= 1).
- FRAC, 0, right-shift amount for mode 3 fixed-point rescale (0 <= FRAC <= N-1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mode  in  2  activation select; sampled at accept.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- g_input  in  2*N*M  garbler share. Element i occupies bits [2N*i+2N-1 : 2N*i] as {r1_i, r2_i}, with r1_i in the upper N bits.
- e_input  in  N*M  evaluator share. Element i = e_input[N*i+N-1 : N*i] = x_i - r1_i.
- out_valid  out  1  result vector valid.
- out_ready  in  1  consumer accepts result.
- o  out  N*M  masked result; element i at [N*i+N-1 : N*i].
- busy  out  1  high in BUSY state.

Behaviour:
- Reset values (async, while rst high):
  - state = IDLE, out_valid = 0, o = 0, busy = 0;
  - internal index and pipeline registers = 0;
  - in_ready = 0 while rst is high.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready = 1. On an edge with in_valid high, capture g_input, e_input and mode into holding registers, set index = 0, go to BUSY.
  - BUSY: in_ready = 0, busy = 1. Input port changes are ignored.
  - DONE: out_valid = 1. o is held stable until an edge with out_ready high, then go to IDLE with out_valid = 0.
- Pipeline, one element per edge; index counts 0..M-1:
  - Stage 1: x_i = (r1_i + e_i) mod 2^N; carry discarded.
  - Stage 2 computes y_i from x_i by latched mode:
    - mode 0, ReLU: y = x[N-1] ? 0 : x.
    - mode 1, identity: y = x.
    - mode 2, DReLU: y = {N-1 zeros, ~x[N-1]}.
    - mode 3, ReLU then logical right shift by FRAC. Applied to the ReLU result, so it is always non-negative.
  - Stage 2 then writes o_i = (y_i - r2_i) mod 2^N into element i of the o register.
- Timing. Let accept be edge E0.
  - x_0 is registered at E1.
  - o_0 is written at E2.
  - o_{M-1} is written at E(M+1); the same edge sets state = DONE and out_valid = 1.
  - Latency is M+1 edges from accept to out_valid.
  - Minimum period between accepts is M+3 edges when out_ready is tied high.
- Other boundary conditions:
  - o is not cleared in IDLE; it retains the last result until overwritten element-by-element in the next BUSY.
  - M = 1: BUSY lasts 2 edges.
  - in_valid high while not IDLE: ignored; no capture, no error.
  - out_ready high outside DONE: ignored.
  - rst asserted mid-BUSY or in DONE: immediate abort to reset values. No out_valid is ever produced for the aborted vector.
  - Mode changes after accept have no effect on the current vector.
  - All additions and subtractions wrap modulo 2^N.

Test Plan:
All scenarios use N=8, M=4, FRAC=2, out_ready=1 unless stated.

1. mode 0, element values for i = 0..3:
   - r1 = {0x10, 0x80, 0xF0, 0x7F}, e = {0x05, 0x00, 0x20, 0x00}, r2 = {0x03, 0x01, 0x00, 0x7F}.
   - Required: o = {0x12, 0xFF, 0x10, 0x00}.
   - Required timing: out_valid rises exactly 5 edges after accept and stays high 1 cycle.
2. mode 2, same inputs as scenario 1 -> o = {0xFE, 0xFF, 0x01, 0x82}.
3. mode 3, same inputs -> element 0: x = 0x15, shifted to 0x05, o_0 = 0x02. Element 1 (x = 0x80, negative): o_1 = 0xFF.
4. mode 1 with mode switched to 0 two edges after accept -> identity is still applied; o_1 = 0x80 - 0x01 = 0x7F.
5. out_ready held low 10 cycles after DONE, with in_valid pulsed meanwhile:
   - out_valid and o stay stable, in_ready stays 0, and the new vector is not captured.
   - On out_ready high, IDLE and in_ready = 1 follow on the next cycle.
6. rst pulsed 2 edges after accept:
   - o = 0, out_valid = 0, busy = 0 immediately.
   - in_ready = 1 after rst is released.
   - No out_valid is ever produced for the aborted vector; a fresh scenario-1 vector then completes correctly.
